// File: rtl/nn_pkg.sv
// Shared sizing, state encoding and stream-index helpers for the perceptron weight streamer.
package nn_pkg;

    localparam int DEF_BITS_PER_WORD      = 8;
    localparam int DEF_INPUT_VECTOR_SIZE  = 2;
    localparam int DEF_HIDDEN_LAYER_SIZE  = 2;
    localparam int DEF_OUTPUT_VECTOR_SIZE = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        CSUM   = 2'd2
    } stream_state_e;

    // layer 0: w1[k][j]; layer 1: w2[k][j] with k the hidden source, j the output neuron
    typedef struct packed {
        logic        layer;
        logic [15:0] k;
        logic [15:0] j;
    } weight_pos_t;

    function automatic int calc_num_weights(input int n_in, input int n_hid, input int n_out);
        return (n_in + 1) * n_hid + (n_hid + 1) * n_out;
    endfunction

    function automatic weight_pos_t index_to_pos(input int idx, input int n_in,
                                                 input int n_hid, input int n_out);
        weight_pos_t pos;
        int          l1_words;
        l1_words = (n_in + 1) * n_hid;
        if (idx < l1_words) begin
            pos.layer = 1'b0;
            pos.k     = 16'(idx / n_hid);
            pos.j     = 16'(idx % n_hid);
        end else begin
            pos.layer = 1'b1;
            pos.k     = 16'((idx - l1_words) / n_out);
            pos.j     = 16'((idx - l1_words) % n_out);
        end
        return pos;
    endfunction

endpackage

// File: rtl/nn_weight_streamer_if.sv
// Weight-load stream between the streamer (master) and the network core (slave).
interface nn_weight_streamer_if
    import nn_pkg::*;
#(
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD
);
    logic                            weights_en;
    logic                            weights_ready;
    logic signed [BITS_PER_WORD-1:0] weights_data;

    modport master (
        output weights_en,
        output weights_data,
        input  weights_ready
    );

    modport slave (
        input  weights_en,
        input  weights_data,
        output weights_ready
    );
endinterface

// File: rtl/nn_weight_regfile.sv
// Weight register file: synchronous write, synchronous clear, asynchronous read.
module nn_weight_regfile
    import nn_pkg::*;
#(
    parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
    parameter int NUM_WEIGHTS   = 9,
    parameter int ADDR_W        = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            we,
    input  logic        [ADDR_W-1:0]        wr_addr,
    input  logic signed [BITS_PER_WORD-1:0] wr_data,
    input  logic        [ADDR_W-1:0]        rd_addr,
    output logic signed [BITS_PER_WORD-1:0] rd_data
);

    logic signed [BITS_PER_WORD-1:0] mem [NUM_WEIGHTS];
    logic                            rd_in_range;

    assign rd_in_range = ({1'b0, rd_addr} < (ADDR_W + 1)'(NUM_WEIGHTS));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WEIGHTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The streamer prefetches one past the last word; that read must not alias.
    assign rd_data = rd_in_range ? mem[rd_addr] : '0;

endmodule

// File: rtl/nn_weight_streamer.sv
// Streams the stored perceptron weight set to the network core with backpressure.
// Optional checksum beat after the last weight: define WEIGHT_STREAM_CHECKSUM_EN.
module nn_weight_streamer
    import nn_pkg::*;
#(
    parameter  int BITS_PER_WORD      = DEF_BITS_PER_WORD,
    parameter  int INPUT_VECTOR_SIZE  = DEF_INPUT_VECTOR_SIZE,
    parameter  int HIDDEN_LAYER_SIZE  = DEF_HIDDEN_LAYER_SIZE,
    parameter  int OUTPUT_VECTOR_SIZE = DEF_OUTPUT_VECTOR_SIZE,
    localparam int NUM_WEIGHTS        = calc_num_weights(INPUT_VECTOR_SIZE, HIDDEN_LAYER_SIZE,
                                                         OUTPUT_VECTOR_SIZE),
    localparam int ADDR_W             = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            wr_en,
    input  logic        [ADDR_W-1:0]        wr_addr,
    input  logic signed [BITS_PER_WORD-1:0] wr_data,
    output logic                            wr_reject,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    nn_weight_streamer_if.master            wif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

    stream_state_e                   state, state_n;
    logic        [ADDR_W-1:0]        word_idx, word_idx_n;
    logic        [ADDR_W-1:0]        rd_addr;
    logic signed [BITS_PER_WORD-1:0] rd_data;
    logic signed [BITS_PER_WORD-1:0] data_q, data_n;
    logic                            en_q, en_n;
    logic                            busy_n, done_n, rej_n;
    logic                            wr_accept, beat;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    logic signed [BITS_PER_WORD-1:0] csum_q, csum_n;
`endif

    assign wr_accept = wr_en && !busy && ({1'b0, wr_addr} < (ADDR_W + 1)'(NUM_WEIGHTS));
    assign beat      = en_q && wif.weights_ready;

    assign wif.weights_en   = en_q;
    assign wif.weights_data = data_q;

    nn_weight_regfile #(
        .BITS_PER_WORD (BITS_PER_WORD),
        .NUM_WEIGHTS   (NUM_WEIGHTS),
        .ADDR_W        (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (wr_accept),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            word_idx  <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_reject <= 1'b0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state     <= state_n;
            word_idx  <= word_idx_n;
            en_q      <= en_n;
            data_q    <= data_n;
            busy      <= busy_n;
            done      <= done_n;
            wr_reject <= rej_n;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
            csum_q    <= csum_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        word_idx_n = word_idx;
        en_n       = en_q;
        data_n     = data_q;
        busy_n     = busy;
        done_n     = 1'b0;
        rej_n      = wr_en && !wr_accept;
        rd_addr    = '0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        csum_n     = csum_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = STREAM;
                    word_idx_n = '0;
                    en_n       = 1'b1;
                    busy_n     = 1'b1;
                    // A write to word 0 in the start cycle must be visible to the first beat.
                    data_n     = (wr_accept && (wr_addr == '0)) ? wr_data : rd_data;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
                    csum_n     = '0;
`endif
                end
            end
            STREAM: begin
                rd_addr = word_idx + ADDR_W'(1);
                if (beat) begin
`ifdef WEIGHT_STREAM_CHECKSUM_EN
                    csum_n = csum_q + data_q;
`endif
                    if (word_idx == LAST_IDX) begin
                        word_idx_n = '0;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
                        state_n    = CSUM;
                        data_n     = csum_q + data_q;
`else
                        state_n    = IDLE;
                        en_n       = 1'b0;
                        busy_n     = 1'b0;
                        done_n     = 1'b1;
                        data_n     = '0;
`endif
                    end else begin
                        word_idx_n = word_idx + ADDR_W'(1);
                        data_n     = rd_data;
                    end
                end
            end
`ifdef WEIGHT_STREAM_CHECKSUM_EN
            CSUM: begin
                if (beat) begin
                    state_n = IDLE;
                    en_n    = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    data_n  = '0;
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_nn_weight_streamer.sv
// Randomized directed bench for nn_weight_streamer against a layer-ordered reference model.
module tb_nn_weight_streamer;

    localparam int BPW  = 8;
    localparam int N_IN = 2;
    localparam int N_HID = 2;
    localparam int N_OUT = 1;
    localparam int NW   = (N_IN + 1) * N_HID + (N_HID + 1) * N_OUT;
    localparam int AW   = 4;
`ifdef WEIGHT_STREAM_CHECKSUM_EN
    localparam int TOTAL = NW + 1;
`else
    localparam int TOTAL = NW;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [BPW-1:0]  wr_data = '0;
    logic            start = 1'b0;
    logic            wr_reject, busy, done;

    int              n_cmp = 0;
    int              n_fail = 0;
    logic [BPW-1:0]  model [NW];
    logic [BPW-1:0]  exp_words [TOTAL];

    nn_weight_streamer_if #(.BITS_PER_WORD(BPW)) wif ();

    nn_weight_streamer #(
        .BITS_PER_WORD      (BPW),
        .INPUT_VECTOR_SIZE  (N_IN),
        .HIDDEN_LAYER_SIZE  (N_HID),
        .OUTPUT_VECTOR_SIZE (N_OUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_reject (wr_reject),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .wif       (wif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected stream: w1[k][j] rows (bias row first), then w2[j][i] rows, then optional sum.
    task automatic build_expected();
        int n = 0;
        int sum = 0;
        for (int k = 0; k <= N_IN; k++)
            for (int j = 0; j < N_HID; j++) begin
                exp_words[n] = model[k * N_HID + j];
                n++;
            end
        for (int j = 0; j <= N_HID; j++)
            for (int i = 0; i < N_OUT; i++) begin
                exp_words[n] = model[(N_IN + 1) * N_HID + j * N_OUT + i];
                n++;
            end
        for (int w = 0; w < NW; w++) sum += int'($signed(model[w]));
`ifdef WEIGHT_STREAM_CHECKSUM_EN
        exp_words[NW] = 8'(sum);
`else
        if (sum == 32'h7fff_ffff) exp_words[0] = exp_words[0];
`endif
    endtask

    task automatic write_word(input int addr, input logic [BPW-1:0] data);
        logic exp_rej;
        exp_rej = busy || (addr >= NW);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = data;
        step();
        wr_en = 1'b0;
        check($sformatf("wr_reject_a%0d", addr), wr_reject, exp_rej);
        if (!exp_rej) model[addr] = data;
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic run_stream(input int mode, input int wr_cycle, input bit wr0,
                              input logic [BPW-1:0] wr0_data);
        int             beats = 0;
        int             cyc = 0;
        int             busy_cyc = 0;
        logic           prev_stall = 1'b0;
        logic [BPW-1:0] prev_data = '0;
        logic           rdy;
        if (wr0) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wr_data = wr0_data;
            model[0] = wr0_data;
        end
        build_expected();
        start = 1'b1;
        step();
        start = 1'b0;
        wr_en = 1'b0;
        check("first_en", wif.weights_en, 1'b1);
        while (beats < TOTAL && cyc < 200) begin
            if (prev_stall) begin
                check("stall_en", wif.weights_en, 1'b1);
                check("stall_data", $unsigned(wif.weights_data), prev_data);
            end
            check("busy_during", busy, 1'b1);
            check("no_early_done", done, 1'b0);
            busy_cyc++;
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            else                rdy = 1'($urandom_range(0, 1));
            wif.weights_ready = rdy;
            wr_en = 1'b0;
            if (cyc == wr_cycle) begin
                wr_en   = 1'b1;
                wr_addr = AW'(3);
                wr_data = 8'h7F;
            end
            if (wr_cycle >= 0 && cyc == wr_cycle + 1) check("busy_wr_reject", wr_reject, 1'b1);
            if (wif.weights_en && rdy) begin
                check($sformatf("beat%0d", beats), $unsigned(wif.weights_data), exp_words[beats]);
                beats++;
                prev_stall = 1'b0;
            end else begin
                prev_stall = wif.weights_en;
                prev_data  = $unsigned(wif.weights_data);
            end
            step();
            cyc++;
        end
        wr_en = 1'b0;
        if (beats < TOTAL) check("stream_timeout", beats, TOTAL);
        check("done_pulse", done, 1'b1);
        check("en_after", wif.weights_en, 1'b0);
        check("busy_after", busy, 1'b0);
        if (mode == 0) check("busy_cycles", busy_cyc, TOTAL);
        step();
        check("done_clear", done, 1'b0);
    endtask

    initial begin
        logic [BPW-1:0] xor_set [NW];
        xor_set = '{8'h00, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h01, 8'hFE};
        for (int i = 0; i < NW; i++) model[i] = '0;
        wif.weights_ready = 1'b0;

        // reset state
        step();
        step();
        check("rst_en", wif.weights_en, 1'b0);
        check("rst_data", $unsigned(wif.weights_data), 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wr_reject", wr_reject, 1'b0);
        reset_n = 1'b1;
        step();

        // XOR set, full-rate and stalled streams
        for (int i = 0; i < NW; i++) write_word(i, xor_set[i]);
        run_stream(0, -1, 1'b0, 8'h00);
        run_stream(1, -1, 1'b0, 8'h00);

        // write while busy is rejected, stream unchanged
        run_stream(0, 2, 1'b0, 8'h00);
        check("idx3_unchanged", model[3], 8'h01);

        // out-of-range write when idle
        write_word(12, 8'h7F);
        run_stream(0, -1, 1'b0, 8'h00);

        // write to word 0 in the start cycle is seen by the first beat
        run_stream(0, -1, 1'b1, 8'h5A);
        write_word(0, 8'h00);

        // start held across done: back-to-back streams
        build_expected();
        wif.weights_ready = 1'b1;
        start = 1'b1;
        step();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < TOTAL; i++) begin
                check($sformatf("held_s%0d_en%0d", s, i), wif.weights_en, 1'b1);
                check($sformatf("held_s%0d_beat%0d", s, i), $unsigned(wif.weights_data),
                      exp_words[i]);
                if (s == 1 && i == 0) start = 1'b0;
                step();
            end
            check($sformatf("held_done%0d", s), done, 1'b1);
            check($sformatf("held_en_off%0d", s), wif.weights_en, 1'b0);
            step();
        end
        check("held_idle", wif.weights_en, 1'b0);

        // reset after beat 4
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("pre_reset_data", $unsigned(wif.weights_data), exp_words[5]);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("midrst_en", wif.weights_en, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", $unsigned(wif.weights_data), 8'h00);
        for (int i = 0; i < NW; i++) model[i] = '0;
        step();
        run_stream(0, -1, 1'b0, 8'h00);

        // random weight sets with random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 12; w++)
                write_word(int'($urandom_range(0, 15)), 8'($urandom));
            run_stream(2, -1, 1'b0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
